// File: rtl/decoder_seq.sv
// Registered one-hot select generator: load, up/down stepping with wrap at LAST, sync clear.
// Define DECODER_SEQ_ERR_EN to add the sticky `err` flag for out-of-range loads.
module decoder_seq #(
    parameter int N    = 4,
    parameter int LAST = (1 << N) - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic               load,
    input  logic [N-1:0]       in,
    input  logic               step,
    input  logic               dir,
    output logic [(1<<N)-1:0]  out,
    output logic [N-1:0]       index,
    output logic               valid,
`ifdef DECODER_SEQ_ERR_EN
    output logic               err,
`endif
    output logic               wrap
);

    localparam int W = 1 << N;
    localparam logic [N-1:0] LAST_IDX = LAST[N-1:0];

    logic          active;
    logic [N-1:0]  index_nxt;
    logic          active_nxt;
    logic          wrap_nxt;
    logic          reject;
    logic [W-1:0]  out_nxt;

    // Priority: clear > enable gate > load > step > hold.
    always_comb begin
        index_nxt  = index;
        active_nxt = active;
        wrap_nxt   = 1'b0;
        reject     = 1'b0;
        if (clear) begin
            index_nxt  = '0;
            active_nxt = 1'b0;
        end else if (enable) begin
            if (load) begin
                if (in <= LAST_IDX) begin
                    index_nxt  = in;
                    active_nxt = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end else if (step && active) begin
                if (!dir) begin
                    if (index == LAST_IDX) begin
                        index_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end else begin
                        index_nxt = index + 1'b1;
                    end
                end else begin
                    if (index == '0) begin
                        index_nxt = LAST_IDX;
                        wrap_nxt  = 1'b1;
                    end else begin
                        index_nxt = index - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        out_nxt = '0;
        if (active_nxt && enable && !clear) begin
            out_nxt[index_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index  <= '0;
            active <= 1'b0;
            out    <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            index  <= index_nxt;
            active <= active_nxt;
            out    <= out_nxt;
            valid  <= |out_nxt;
            wrap   <= wrap_nxt;
        end
    end

`ifdef DECODER_SEQ_ERR_EN
    // Sticky until clear or reset; reject is never raised in a clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (reject) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parameterised one-hot select generator for the datapath's register-file and bus-select lines. It extends plain combinational N-to-2^N decoding with held select state, direct load, up/down stepping with programmable wrap-around, and synchronous clear. All outputs are registered, so select lines are glitch-free and stable for a full cycle.

## Interface
- N, 4, index width; `out` is 2^N bits wide
- LAST, 2^N-1, highest legal index; must satisfy 0 ≤ LAST ≤ 2^N-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1: state may change and `out` is driven; 0: state frozen and `out` forced to 0
- clear  in  1  synchronous clear of sequencer state
- load  in  1  load `in` as the new index
- in  in  N  index to load
- step  in  1  advance the index by one position
- dir  in  1  step direction: 0 up, 1 down
- out  out  2^N  registered one-hot select; all zeros when idle or disabled
- index  out  N  current index register
- valid  out  1  registered; 1 when `out` is non-zero
- wrap  out  1  registered one-cycle pulse on a wrapping step
- err  out  1  sticky out-of-range flag; present only with DECODER_SEQ_ERR_EN

## Operation
- State consists of `index` (N bits) and `active` (1 bit).
- Priority per cycle is fixed: clear > (enable gate) > load > step > hold.
- **clear** = 1, regardless of `enable`:
  - index ← 0, active ← 0
  - next `out` = 0, `valid` = 0, `wrap` = 0
- **enable** = 0 (and no clear):
  - `load` and `step` are ignored; `index` and `active` are held.
  - Next `out` = 0, `valid` = 0, `wrap` = 0.
- **load** = 1:
  - If `in` ≤ LAST: index ← in, active ← 1.
  - If `in` > LAST: load is rejected and state is held (err sets when the macro is compiled in).
  - `step` in the same cycle is ignored.
- **step** = 1 with active = 1:
  - dir = 0: index ← index+1; if index == LAST, index ← 0 and `wrap` pulses.
  - dir = 1: index ← index−1; if index == 0, index ← LAST and `wrap` pulses.
- **step** = 1 with active = 0: ignored, no wrap pulse.
- **Output:** next `out` = (active_next & enable) ? (1 << index_next) : 0.
  - `valid` = |`out`.
  - Exactly zero or one bit of `out` is ever set.
- **LAST = 0:** a step leaves index at 0 and pulses `wrap` every stepping cycle.
- **Index arithmetic:** modulo LAST+1, never modulo 2^N. Indices above LAST are unreachable except via a LAST > 2^N−1 misconfiguration, which is illegal.

## Timing
- **Reset** (rst_n low, asynchronous):
  - index = 0, active = 0, out = 0, valid = 0, wrap = 0, err = 0.
  - Outputs remain 0 until the first accepted load after rst_n deasserts.
- **Latency:** one cycle. A load or step sampled at edge k is visible on `out`, `index`, `valid` and `wrap` after edge k.
- **Hold:** `out` holds between events; `wrap` is high for exactly one cycle per wrapping step.
- **Re-enable:** after `enable` returns to 1, `out` reflects the held index one cycle later, with no step applied.
- **Reset mid-sequence:** state is discarded immediately and no wrap pulse is emitted.
- **Back-to-back steps:** one index change per cycle, with no bubbles.

## Configuration
- DECODER_SEQ_ERR_EN defined:
  - Adds the `err` port.
  - `err` sets on the cycle after a rejected load (`in` > LAST with enable = 1, clear = 0).
  - `err` remains set until `clear` or reset.
- Undefined:
  - No `err` port and no error logic.
  - Out-of-range loads are silently rejected; all other behaviour is identical.

## Test plan
All scenarios use N=3, LAST=5.
- **Reset then load:** rst_n low, then high; load in=3 → after one edge out=8'b0000_1000, index=3, valid=1, wrap=0.
- **Up-wrap:** load 4, then step dir=0 for 3 cycles → index 5, 0, 1; wrap=1 only in the cycle index=0; out=8'h20, 8'h01, 8'h02.
- **Down-wrap:** load 0, step dir=1 → index=5, out=8'h20, wrap=1 for one cycle.
- **Priority:** load=1, step=1, in=2 in the same cycle → index=2 (no step applied); clear=1 with load=1 → out=0, index=0, valid=0.
- **Enable gating:** at index=1, enable=0 with step=1 for 2 cycles → out=0, index stays 1; enable=1 → out=8'h02 one cycle later.
- **Out-of-range:** load in=7 while index=2 → index stays 2, out unchanged; with DECODER_SEQ_ERR_EN, err=1 until clear, and async rst_n mid-sequence clears all outputs to 0.
